key_load_ctrl: RTL and testbench

Serial key loader that sits directly upstream of the XOR-locked 16-bit carry-lookahead adder and drives its 32-bit `keyinput` bus. It receives the key one bit per handshake, MSB-first, followed by an 8-bit checksum trailer. It commits the key to the adder only when the checksum matches. It flags when the key bus holds a verified key, so downstream logic can qualify `result_o`.

---
 rtl/key_load_ctrl.sv | 94 +++++++++
 tb/tb_key_load_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/key_load_ctrl.sv
// Serial key loader for the XOR-locked adder: shifts in key + checksum MSB-first,
// then commits the key only when the XOR of its bytes matches the trailer.
module key_load_ctrl #(
   parameter int KEY_W = 32,
   parameter int CHK_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             key_start_i,
   input  logic             key_bit_i,
   input  logic             key_bit_valid_i,
   output logic             key_bit_ready_o,
   output logic [KEY_W-1:0] keyinput_o,
   output logic             key_valid_o,
   output logic             key_err_o,
   output logic             busy_o
);

   localparam int SH_W  = KEY_W + CHK_W;
   localparam int CNT_W = $clog2(SH_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SH_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CHECK
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [SH_W-1:0]  shadow;

   function automatic logic [CHK_W-1:0] key_xor(input logic [KEY_W-1:0] k);
      logic [CHK_W-1:0] r;
      r = '0;
      for (int i = 0; i < KEY_W / 8; i++) r = r ^ k[i*8 +: 8];
      return r;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= IDLE;
         cnt             <= '0;
         shadow          <= '0;
         keyinput_o      <= '0;
         key_valid_o     <= 1'b0;
         key_err_o       <= 1'b0;
         key_bit_ready_o <= 1'b0;
         busy_o          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (key_start_i) begin
                  state           <= LOAD;
                  cnt             <= '0;
                  shadow          <= '0;
                  key_valid_o     <= 1'b0;
                  key_err_o       <= 1'b0;
                  key_bit_ready_o <= 1'b1;
                  busy_o          <= 1'b1;
               end
            end
            LOAD: begin
               // Stall cycles (valid low) leave everything untouched.
               if (key_bit_valid_i) begin
                  shadow <= {shadow[SH_W-2:0], key_bit_i};
                  cnt    <= cnt + 1'b1;
                  if (cnt == LAST_BIT) begin
                     state           <= CHECK;
                     key_bit_ready_o <= 1'b0;
                  end
               end
            end
            CHECK: begin
               // keyinput_o is the only copy the adder sees, so it moves only on a verified key.
               if (key_xor(shadow[SH_W-1:CHK_W]) == shadow[CHK_W-1:0]) begin
                  keyinput_o  <= shadow[SH_W-1:CHK_W];
                  key_valid_o <= 1'b1;
               end else begin
                  key_err_o <= 1'b1;
               end
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state           <= IDLE;
               key_bit_ready_o <= 1'b0;
               busy_o          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl: expected commit results are queued at each
// start and compared when the loader returns to idle.
module tb_key_load_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_start = 1'b0;
   logic        key_bit = 1'b0;
   logic        key_bit_valid = 1'b0;
   logic        ready;
   logic [31:0] keyinput;
   logic        kv;
   logic        ke;
   logic        busy;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic [31:0] key;
      logic        valid;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] committed = 32'h0;

   key_load_ctrl #(.KEY_W(32), .CHK_W(8)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .key_start_i     (key_start),
      .key_bit_i       (key_bit),
      .key_bit_valid_i (key_bit_valid),
      .key_bit_ready_o (ready),
      .keyinput_o      (keyinput),
      .key_valid_o     (kv),
      .key_err_o       (ke),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_chk(input logic [31:0] k);
      return k[31:24] ^ k[23:16] ^ k[15:8] ^ k[7:0];
   endfunction

   task automatic load(input logic [31:0] key, input logic [7:0] chk, input bit stall,
                       input int restart_at, input int exp_cycles);
      logic [39:0] sh;
      exp_t        e;
      int          cyc;
      sh = {key, chk};
      if (model_chk(key) == chk) begin
         e.key = key; e.valid = 1'b1; e.err = 1'b0;
      end else begin
         e.key = committed; e.valid = 1'b0; e.err = 1'b1;
      end
      sb.push_back(e);

      key_start = 1'b1;
      step();
      key_start = 1'b0;
      check("start_busy", busy, 1);
      check("start_ready", ready, 1);
      check("start_valid", kv, 0);
      check("start_err", ke, 0);

      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (stall) begin
            key_bit_valid = 1'b0;
            key_bit = ~sh[39-i];
            step();
            cyc++;
            check("stall_key_hold", keyinput, committed);
         end
         key_bit       = sh[39-i];
         key_bit_valid = 1'b1;
         key_start     = (i == restart_at);
         step();
         cyc++;
         key_start = 1'b0;
         check("load_key_hold", keyinput, committed);
         check("load_valid_low", kv, 0);
      end
      key_bit_valid = 1'b0;
      check("check_busy", busy, 1);
      check("check_ready", ready, 0);

      step();
      cyc++;
      check("commit_cycles", cyc, exp_cycles);
      check("idle_busy", busy, 0);
      check("idle_ready", ready, 0);
      e = sb.pop_front();
      check("commit_key", keyinput, e.key);
      check("commit_valid", kv, e.valid);
      check("commit_err", ke, e.err);
      check("valid_err_exclusive", kv & ke, 0);
      if (e.valid) committed = e.key;
   endtask

   initial begin
      // Power-on reset
      step();
      step();
      check("rst_key", keyinput, 0);
      check("rst_valid", kv, 0);
      check("rst_err", ke, 0);
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();

      // Bad checksum straight after reset: key stays 0, error flagged
      load(32'hF17B83DB, 8'hD3, 1'b0, -1, 41);
      // Good load, continuous valid
      load(32'hF17B83DB, 8'hD2, 1'b0, -1, 41);
      // Good load with a stall before every bit
      load(32'hF17B83CB, 8'hC2, 1'b1, -1, 81);
      // Stray start pulse at bit 10
      load(32'hF17B83DB, 8'hD2, 1'b0, 10, 41);

      // Reset in the middle of a load that follows a committed key
      key_start = 1'b1;
      step();
      key_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         key_bit       = i[0];
         key_bit_valid = 1'b1;
         step();
      end
      rst_n = 1'b0;
      #1;
      check("midrst_key", keyinput, 0);
      check("midrst_valid", kv, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", ready, 0);
      check("midrst_err", ke, 0);
      key_bit_valid = 1'b0;
      committed = 32'h0;
      step();
      step();
      rst_n = 1'b1;
      step();
      load(32'hF17B83DB, 8'hD2, 1'b0, -1, 41);

      // Stray valid bits while idle must not be captured
      for (int i = 0; i < 6; i++) begin
         key_bit       = 1'b1;
         key_bit_valid = 1'b1;
         step();
         check("stray_busy", busy, 0);
         check("stray_key", keyinput, committed);
      end
      key_bit_valid = 1'b0;
      load(32'h12345678, 8'h08, 1'b0, -1, 41);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
